rv32i_memtop: RTL and testbench
===============================

Name: rv32i_memTop

Overview:
- Memory-access stage of the RV32I pipeline. Consumes the registered results of the execute stage: ALU result/address, rs2 data, instruction word, PC and writeback tags.
- Performs loads and stores over a req/ack data-memory bus with variable latency. Steers and masks byte lanes, and sign- or zero-extends load data.
- Stalls upstream while a bus transaction is outstanding, then forwards writeback data to the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_req may stay high without mem_ack before the access is aborted (must be ≥2).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  execute-stage output holds a valid instruction
- pc_in  in  32  instruction PC
- iw_in  in  32  instruction word; opcode [6:0], func3 [14:12]
- alu_in  in  32  ALU result; effective address for loads and stores
- rs2_data_in  in  32  store data
- wb_en_in  in  1  instruction writes rd
- wb_reg_in  in  5  destination register
- stall_out  out  1  upstream must hold all inputs unchanged
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address {alu[31:2],2'b00}
- mem_wdata  out  32  lane-steered store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  single-cycle completion strobe
- valid_out  out  1  outputs hold a valid instruction for writeback
- pc_out, iw_out  out  32 each  passed through
- wb_data_out  out  32  value to write to rd
- wb_en_out  out  1  writeback enable (qualified)
- wb_reg_out  out  5  passed through
- misalign_err  out  1  access was misaligned; aborted
- bus_err  out  1  access timed out; aborted

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs are 0; mem_req, mem_we and mem_be are 0.
- States: IDLE, BUS. stall_out = (state==BUS). All mem_* outputs are driven from registers captured at acceptance.
- IDLE, on a rising edge with valid_in=1:
  - Non-memory opcode (not 0000011/0100011): on the next edge, valid_out=1, wb_data_out=alu_in, wb_en_out=wb_en_in, other fields pass through, both error flags 0. Latency is 1 cycle.
  - Load or store with legal func3 and aligned address: latch the operation, go to BUS. valid_out=0 that cycle.
  - Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. Such an access makes no bus transaction: next cycle valid_out=1, misalign_err=1, wb_en_out=0.
  - Illegal load/store func3 is treated as a non-memory pass-through with wb_en_out=0.
- IDLE with valid_in=0: valid_out=0; other outputs hold.
- BUS:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are stable for the whole transaction.
  - Counter increments each cycle.
- mem_ack=1 in BUS:
  - Load: wb_data_out = extended data, wb_en_out=wb_en_in.
  - Store: wb_en_out=0, wb_data_out=0.
  - valid_out=1 on the next edge; return to IDLE. mem_req drops the cycle after ack.
  - Minimum memory-op latency is 2 cycles (ack in the first BUS cycle).
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no ack, go to IDLE with valid_out=1, bus_err=1, wb_en_out=0. mem_req drops. A late ack arriving in IDLE is ignored.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 1<<addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Loads: mem_be = 1111 and the full word is read. Select the byte or halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- valid_out is a single-cycle pulse per accepted instruction. The cycle after ack, stall_out=0 and the next instruction is accepted (one bubble).
- Reset mid-BUS: mem_req deasserts immediately and the in-flight instruction is discarded with no valid_out.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode constants OP_LOAD and OP_STORE.
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Enum mem_state_t {IDLE, BUS}.
- Sub-module rv32i_memLane, purely combinational:
  - Store direction: store lane steering and byte enables.
  - Load direction: load extraction and extension.
  - Also produces the misalignment flag.

Test Plan:
- ADDI, valid_in=1, alu_in=0x0000002A, wb_reg=5 → next cycle valid_out=1, wb_data_out=0x2A, wb_en_out=1, mem_req never high.
- SB with alu=0x202 and rs2=0x000000AB; ack in the 3rd BUS cycle:
  - mem_addr=0x200, wdata=0xABABABAB, be=0100, mem_we=1.
  - stall_out high for 3 cycles.
  - valid_out=1 with wb_en_out=0 after ack.
- LB with alu=0x103, rdata=0x80123456 → wb_data_out=0xFFFFFF80. LBU with the same values → 0x00000080. LHU with alu=0x102 → 0x00008012.
- LW with alu=0x101 → no mem_req, valid_out=1, misalign_err=1, wb_en_out=0 one cycle later.
- Store with mem_ack held low → mem_req high for exactly 16 cycles, then valid_out=1 and bus_err=1. An ack arriving 2 cycles later has no effect.
- Reset asserted in the 2nd BUS cycle → mem_req=0 and valid_out=0 immediately. After release, an ADDI completes normally in 1 cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I memory-access stage.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUS} mem_state_t;

endpackage

// File: rtl/rv32i_memlane.sv
// Byte-lane logic: store steering/enables, load extraction/extension,
// and misalignment / illegal-func3 classification.
module rv32i_memlane
  import rv32i_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
  end

  assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata     = rs2_data;
    be        = 4'b1111;
    load_data = rdata;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (func3)
      F3_B: begin
        load_data = {{24{ld_byte[7]}}, ld_byte};
        if (is_store) begin
          wdata = {4{rs2_data[7:0]}};
          be    = 4'b0001 << addr_lo;
        end
      end
      F3_H: begin
        misalign  = addr_lo[0];
        load_data = {{16{ld_half[15]}}, ld_half};
        if (is_store) begin
          wdata = {2{rs2_data[15:0]}};
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: misalign = |addr_lo;
      F3_BU: begin
        illegal   = is_store;
        load_data = {24'd0, ld_byte};
      end
      F3_HU: begin
        illegal   = is_store;
        misalign  = addr_lo[0];
        load_data = {16'd0, ld_half};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_memtop.sv
// RV32I memory-access stage: issues loads/stores on a req/ack bus, stalls
// upstream while busy, and forwards writeback results.
module rv32i_memtop
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_reg_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          accept, complete, timeout;

  logic        is_load, is_store, is_mem;
  logic [31:0] lane_wdata, lane_load;
  logic [3:0]  lane_be;
  logic        lane_misalign, lane_illegal;

  assign is_load  = (iw_in[6:0] == OP_LOAD);
  assign is_store = (iw_in[6:0] == OP_STORE);
  assign is_mem   = is_load | is_store;

  // Upstream holds its inputs while stalled, so the same lane instance
  // serves both acceptance (store steering) and completion (load extraction).
  rv32i_memlane u_lane (
    .is_store  (is_store),
    .func3     (iw_in[14:12]),
    .addr_lo   (alu_in[1:0]),
    .rs2_data  (rs2_data_in),
    .rdata     (mem_rdata),
    .wdata     (lane_wdata),
    .be        (lane_be),
    .load_data (lane_load),
    .misalign  (lane_misalign),
    .illegal   (lane_illegal)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_in && is_mem && !lane_illegal && !lane_misalign) begin
          state_next = BUS;
          cnt_next   = '0;
          accept     = 1'b1;
        end
      end
      BUS: begin
        if (mem_ack) begin
          state_next = IDLE;
          cnt_next   = '0;
          complete   = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign stall_out = (state_reg == BUS);
  assign mem_req   = (state_reg == BUS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      valid_out    <= 1'b0;
      pc_out       <= '0;
      iw_out       <= '0;
      wb_data_out  <= '0;
      wb_en_out    <= 1'b0;
      wb_reg_out   <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        mem_we    <= is_store;
        mem_addr  <= {alu_in[31:2], 2'b00};
        mem_wdata <= lane_wdata;
        mem_be    <= lane_be;
      end
      // Non-memory, illegal-func3 and misaligned instructions retire directly.
      if (state_reg == IDLE && valid_in && !accept) begin
        valid_out    <= 1'b1;
        pc_out       <= pc_in;
        iw_out       <= iw_in;
        wb_reg_out   <= wb_reg_in;
        wb_data_out  <= alu_in;
        wb_en_out    <= wb_en_in && !is_mem;
        misalign_err <= is_mem && !lane_illegal && lane_misalign;
        bus_err      <= 1'b0;
      end
      if (complete || timeout) begin
        valid_out    <= 1'b1;
        pc_out       <= pc_in;
        iw_out       <= iw_in;
        wb_reg_out   <= wb_reg_in;
        wb_data_out  <= (complete && !mem_we) ? lane_load : 32'd0;
        wb_en_out    <= complete && !mem_we && wb_en_in;
        misalign_err <= 1'b0;
        bus_err      <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_memtop.sv
// Directed self-checking bench for the RV32I memory-access stage.
module tb_rv32i_memtop;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic        wb_en_in;
  logic [4:0]  wb_reg_in;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        valid_out;
  logic [31:0] pc_out, iw_out, wb_data_out;
  logic        wb_en_out;
  logic [4:0]  wb_reg_out;
  logic        misalign_err, bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls;

  rv32i_memtop #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .pc_in        (pc_in),
    .iw_in        (iw_in),
    .alu_in       (alu_in),
    .rs2_data_in  (rs2_data_in),
    .wb_en_in     (wb_en_in),
    .wb_reg_in    (wb_reg_in),
    .stall_out    (stall_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .valid_out    (valid_out),
    .pc_out       (pc_out),
    .iw_out       (iw_out),
    .wb_data_out  (wb_data_out),
    .wb_en_out    (wb_en_out),
    .wb_reg_out   (wb_reg_out),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_iw(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd7, opc};
  endfunction

  task automatic drive(input logic [31:0] iw, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] wreg);
    valid_in    = 1'b1;
    iw_in       = iw;
    alu_in      = alu;
    rs2_data_in = rs2;
    wb_en_in    = 1'b1;
    wb_reg_in   = wreg;
    pc_in       = pc_in + 32'd4;
  endtask

  // Issues a memory op, acks in BUS cycle ack_at (0 = never), and stops
  // in the cycle after the stage leaves BUS.
  task automatic mem_op(input string tag, input logic [31:0] iw, input logic [31:0] alu,
                        input logic [31:0] rs2, input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_be, input logic exp_we, output int n_stall);
    drive(iw, alu, rs2, 5'd9);
    tick();
    n_stall = 0;
    check_val({tag, "_vld_accept"}, 32'(valid_out), 32'd0);
    for (int c = 1; c <= 40 && stall_out === 1'b1; c++) begin
      n_stall++;
      check_val({tag, "_req"}, 32'(mem_req), 32'd1);
      check_val({tag, "_addr"}, mem_addr, exp_addr);
      check_val({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      check_val({tag, "_we"}, 32'(mem_we), 32'(exp_we));
      if (exp_we) check_val({tag, "_wdata"}, mem_wdata, exp_wdata);
      if (c == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEADBEEF;
    end
    valid_in = 1'b0;
    check_val({tag, "_vld"}, 32'(valid_out), 32'd1);
    check_val({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    check_val({tag, "_wb_reg"}, 32'(wb_reg_out), 32'd9);
    $display("txn %s: stalls=%0d wb_data=0x%08h wb_en=%0b bus_err=%0b",
             tag, n_stall, wb_data_out, wb_en_out, bus_err);
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; pc_in = 32'h1000; iw_in = '0; alu_in = '0;
    rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    check_val("rst_valid", 32'(valid_out), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_be", 32'(mem_be), 32'd0);
    check_val("rst_stall", 32'(stall_out), 32'd0);
    check_val("rst_wb_data", wb_data_out, 32'd0);
    $display("txn reset");
    reset = 1'b1;
    tick();

    // ADDI x5
    drive(mk_iw(7'b0010011, 3'b000), 32'h0000002A, 32'h0, 5'd5);
    check_val("addi_req_pre", 32'(mem_req), 32'd0);
    tick();
    valid_in = 1'b0;
    check_val("addi_valid", 32'(valid_out), 32'd1);
    check_val("addi_data", wb_data_out, 32'h2A);
    check_val("addi_wb_en", 32'(wb_en_out), 32'd1);
    check_val("addi_wb_reg", 32'(wb_reg_out), 32'd5);
    check_val("addi_pc", pc_out, 32'h1004);
    check_val("addi_req", 32'(mem_req), 32'd0);
    $display("txn addi: wb_data=0x%08h", wb_data_out);
    tick();
    check_val("addi_pulse", 32'(valid_out), 32'd0);

    // SB, ack in third BUS cycle
    mem_op("sb", mk_iw(OP_STORE, F3_B), 32'h202, 32'h000000AB, 3, 32'h0,
           32'h200, 32'hABABABAB, 4'b0100, 1'b1, stalls);
    check_val("sb_stalls", 32'(stalls), 32'd3);
    check_val("sb_wb_en", 32'(wb_en_out), 32'd0);
    check_val("sb_wb_data", wb_data_out, 32'd0);

    // SH upper half, ack in second BUS cycle
    mem_op("sh", mk_iw(OP_STORE, F3_H), 32'h206, 32'h0000BEEF, 2, 32'h0,
           32'h204, 32'hBEEFBEEF, 4'b1100, 1'b1, stalls);
    check_val("sh_stalls", 32'(stalls), 32'd2);

    // Loads, ack in first BUS cycle (minimum latency)
    mem_op("lb", mk_iw(OP_LOAD, F3_B), 32'h103, 32'h0, 1, 32'h80123456,
           32'h100, 32'h0, 4'b1111, 1'b0, stalls);
    check_val("lb_stalls", 32'(stalls), 32'd1);
    check_val("lb_data", wb_data_out, 32'hFFFFFF80);
    check_val("lb_wb_en", 32'(wb_en_out), 32'd1);
    mem_op("lbu", mk_iw(OP_LOAD, F3_BU), 32'h103, 32'h0, 1, 32'h80123456,
           32'h100, 32'h0, 4'b1111, 1'b0, stalls);
    check_val("lbu_data", wb_data_out, 32'h00000080);
    mem_op("lhu", mk_iw(OP_LOAD, F3_HU), 32'h102, 32'h0, 1, 32'h80123456,
           32'h100, 32'h0, 4'b1111, 1'b0, stalls);
    check_val("lhu_data", wb_data_out, 32'h00008012);
    mem_op("lh", mk_iw(OP_LOAD, F3_H), 32'h102, 32'h0, 2, 32'h80123456,
           32'h100, 32'h0, 4'b1111, 1'b0, stalls);
    check_val("lh_data", wb_data_out, 32'hFFFF8012);
    mem_op("lw", mk_iw(OP_LOAD, F3_W), 32'h104, 32'h0, 1, 32'h80123456,
           32'h104, 32'h0, 4'b1111, 1'b0, stalls);
    check_val("lw_data", wb_data_out, 32'h80123456);

    // Misaligned LW
    drive(mk_iw(OP_LOAD, F3_W), 32'h101, 32'h0, 5'd3);
    tick();
    valid_in = 1'b0;
    check_val("mis_req", 32'(mem_req), 32'd0);
    check_val("mis_valid", 32'(valid_out), 32'd1);
    check_val("mis_err", 32'(misalign_err), 32'd1);
    check_val("mis_wb_en", 32'(wb_en_out), 32'd0);
    $display("txn misaligned lw: misalign_err=%0b", misalign_err);
    tick();
    check_val("mis_req_after", 32'(mem_req), 32'd0);

    // Illegal load func3 passes through without writeback
    drive(mk_iw(OP_LOAD, 3'b011), 32'h77, 32'h0, 5'd4);
    tick();
    valid_in = 1'b0;
    check_val("ill_req", 32'(mem_req), 32'd0);
    check_val("ill_valid", 32'(valid_out), 32'd1);
    check_val("ill_data", wb_data_out, 32'h77);
    check_val("ill_wb_en", 32'(wb_en_out), 32'd0);
    check_val("ill_mis", 32'(misalign_err), 32'd0);
    $display("txn illegal func3: wb_data=0x%08h", wb_data_out);
    tick();

    // Store timeout, then a late ack two cycles later
    mem_op("sw_to", mk_iw(OP_STORE, F3_W), 32'h300, 32'h12345678, 0, 32'h0,
           32'h300, 32'h12345678, 4'b1111, 1'b1, stalls);
    check_val("to_req_cycles", 32'(stalls), 32'd16);
    check_val("to_bus_err", 32'(bus_err), 32'd1);
    check_val("to_wb_en", 32'(wb_en_out), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    check_val("late_ack_valid", 32'(valid_out), 32'd0);
    check_val("late_ack_req", 32'(mem_req), 32'd0);
    check_val("late_ack_stall", 32'(stall_out), 32'd0);
    $display("txn late ack ignored");

    // Reset in the second BUS cycle
    drive(mk_iw(OP_STORE, F3_W), 32'h400, 32'h11112222, 5'd6);
    tick();
    check_val("rb_req1", 32'(mem_req), 32'd1);
    tick();
    check_val("rb_req2", 32'(mem_req), 32'd1);
    reset = 1'b0;
    valid_in = 1'b0;
    #1;
    check_val("rb_req_async", 32'(mem_req), 32'd0);
    check_val("rb_valid_async", 32'(valid_out), 32'd0);
    tick();
    check_val("rb_valid_hold", 32'(valid_out), 32'd0);
    $display("txn reset mid-bus");
    reset = 1'b1;
    tick();
    drive(mk_iw(7'b0010011, 3'b000), 32'h55, 32'h0, 5'd8);
    tick();
    valid_in = 1'b0;
    check_val("post_rst_valid", 32'(valid_out), 32'd1);
    check_val("post_rst_data", wb_data_out, 32'h55);
    check_val("post_rst_wb_en", 32'(wb_en_out), 32'd1);
    $display("txn addi after reset: wb_data=0x%08h", wb_data_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
